// File: rtl/mult_fu_pkg.sv
// Shared machine types for the multiply unit: data/tag/mask types, the MULT_FUNC enum
// and the `PHYS_ZERO_REG tag that an empty output carries.
`ifndef PHYS_ZERO_REG
`define PHYS_ZERO_REG 6'd31
`endif

package mult_fu_pkg;

    localparam int DATA_W      = 64;
    localparam int PHYS_REG_W  = 6;
    localparam int BMASK_W_DEF = 4;

    typedef logic [DATA_W-1:0]              DATA;
    typedef logic [PHYS_REG_W-1:0]          PHYS_REG;
    typedef logic [BMASK_W_DEF-1:0]         B_MASK;
    typedef logic [$clog2(BMASK_W_DEF)-1:0] BS_PTR;

    typedef enum logic {
        MULQ  = 1'b0,
        UMULH = 1'b1
    } MULT_FUNC;

    localparam PHYS_REG PHYS_ZERO = `PHYS_ZERO_REG;

endpackage

// File: rtl/mult_fu_stage.sv
// One multiply pipeline register: adds this stage's opB-slice partial product into the
// accumulator and applies branch squash / mask-clear to both the held and the incoming op.
module mult_stage
    import mult_fu_pkg::*;
#(
    parameter int STAGE_IDX = 0,
    parameter int STAGES    = 4,
    parameter int BMASK_W   = 4,
    parameter int PTR_W     = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               stall,
    input  logic               prev_valid,
    input  logic [63:0]        prev_opA,
    input  logic [63:0]        prev_opB,
    input  logic [5:0]         prev_tag,
    input  MULT_FUNC           prev_func,
    input  logic [BMASK_W-1:0] prev_bmask,
    input  logic [127:0]       prev_acc,
    input  logic               br_en,
    input  logic               br_mispredict,
    input  logic [PTR_W-1:0]   br_bs_ptr,
    output logic               cur_valid,
    output logic [63:0]        cur_opA,
    output logic [63:0]        cur_opB,
    output logic [5:0]         cur_tag,
    output MULT_FUNC           cur_func,
    output logic [BMASK_W-1:0] cur_bmask,
    output logic [127:0]       cur_acc
);

    localparam int W     = 64 / STAGES;
    localparam int SHIFT = W * STAGE_IDX;

    logic [BMASK_W-1:0] br_bit;
    logic [BMASK_W-1:0] kill_mask;
    logic [BMASK_W-1:0] clear_mask;
    logic               squash_prev;
    logic               squash_cur;
    logic [127:0]       partial;

    always_comb begin
        br_bit      = BMASK_W'(1) << br_bs_ptr;
        kill_mask   = (br_en &  br_mispredict) ? br_bit : '0;
        clear_mask  = (br_en & ~br_mispredict) ? br_bit : '0;
        squash_prev = |(prev_bmask & kill_mask);
        squash_cur  = |(cur_bmask & kill_mask);
        partial     = (128'(prev_opA) * 128'(prev_opB[SHIFT +: W])) << SHIFT;
    end

    // Squash and mask-clear act on whatever the register will hold, stalled or not.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_valid <= 1'b0;
            cur_opA   <= '0;
            cur_opB   <= '0;
            cur_tag   <= PHYS_ZERO;
            cur_func  <= MULQ;
            cur_bmask <= '0;
            cur_acc   <= '0;
        end else if (stall) begin
            cur_valid <= cur_valid & ~squash_cur;
            cur_bmask <= cur_bmask & ~clear_mask;
        end else begin
            cur_valid <= prev_valid & ~squash_prev;
            cur_opA   <= prev_opA;
            cur_opB   <= prev_opB;
            cur_tag   <= prev_tag;
            cur_func  <= prev_func;
            cur_bmask <= prev_bmask & ~clear_mask;
            cur_acc   <= prev_acc + partial;
        end
    end

endmodule

// File: rtl/mult_fu.sv
// Pipelined 64x64 multiply unit feeding the CDB, built from STAGES mult_stage registers.
// Optional MULT_PERF_EN adds issue and stall counters.
module mult_fu
    import mult_fu_pkg::*;
#(
    parameter int STAGES  = 4,
    parameter int BMASK_W = 4,
    localparam int PTR_W  = (BMASK_W > 1) ? $clog2(BMASK_W) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               fus_en,
    input  logic [63:0]        fus_opA,
    input  logic [63:0]        fus_opB,
    input  logic [5:0]         fus_tagDest,
    input  MULT_FUNC           fus_func,
    input  logic [BMASK_W-1:0] fus_bmask,
    input  logic               br_en,
    input  logic               br_mispredict,
    input  logic [PTR_W-1:0]   br_bs_ptr,
    input  logic               cdb_grant,
    output logic               mult_ready,
    output logic               mult_valid,
    output logic [63:0]        mult_result,
    output logic [5:0]         mult_tagDest,
    output logic [BMASK_W-1:0] mult_bmask
`ifdef MULT_PERF_EN
    ,
    output logic [31:0]        mult_issue_cnt,
    output logic [31:0]        mult_stall_cnt
`endif
);

    localparam int LAST = STAGES - 1;

    logic               s_valid [STAGES];
    logic [63:0]        s_opA   [STAGES];
    logic [63:0]        s_opB   [STAGES];
    logic [5:0]         s_tag   [STAGES];
    MULT_FUNC           s_func  [STAGES];
    logic [BMASK_W-1:0] s_bmask [STAGES];
    logic [127:0]       s_acc   [STAGES];

    logic               stall;
    logic [BMASK_W-1:0] br_bit;
    logic [BMASK_W-1:0] kill_mask;
    logic [BMASK_W-1:0] clear_mask;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic               p_valid;
        logic [63:0]        p_opA;
        logic [63:0]        p_opB;
        logic [5:0]         p_tag;
        MULT_FUNC           p_func;
        logic [BMASK_W-1:0] p_bmask;
        logic [127:0]       p_acc;

        if (i == 0) begin : g_head
            assign p_valid = fus_en;
            assign p_opA   = fus_opA;
            assign p_opB   = fus_opB;
            assign p_tag   = fus_tagDest;
            assign p_func  = fus_func;
            assign p_bmask = fus_bmask;
            assign p_acc   = '0;
        end else begin : g_body
            assign p_valid = s_valid[i-1];
            assign p_opA   = s_opA[i-1];
            assign p_opB   = s_opB[i-1];
            assign p_tag   = s_tag[i-1];
            assign p_func  = s_func[i-1];
            assign p_bmask = s_bmask[i-1];
            assign p_acc   = s_acc[i-1];
        end

        mult_stage #(
            .STAGE_IDX (i),
            .STAGES    (STAGES),
            .BMASK_W   (BMASK_W),
            .PTR_W     (PTR_W)
        ) u_stage (
            .clk           (clk),
            .reset_n       (reset_n),
            .stall         (stall),
            .prev_valid    (p_valid),
            .prev_opA      (p_opA),
            .prev_opB      (p_opB),
            .prev_tag      (p_tag),
            .prev_func     (p_func),
            .prev_bmask    (p_bmask),
            .prev_acc      (p_acc),
            .br_en         (br_en),
            .br_mispredict (br_mispredict),
            .br_bs_ptr     (br_bs_ptr),
            .cur_valid     (s_valid[i]),
            .cur_opA       (s_opA[i]),
            .cur_opB       (s_opB[i]),
            .cur_tag       (s_tag[i]),
            .cur_func      (s_func[i]),
            .cur_bmask     (s_bmask[i]),
            .cur_acc       (s_acc[i])
        );
    end

    // A mispredict kills the output op in the same cycle, which also releases the stall.
    always_comb begin
        br_bit       = BMASK_W'(1) << br_bs_ptr;
        kill_mask    = (br_en &  br_mispredict) ? br_bit : '0;
        clear_mask   = (br_en & ~br_mispredict) ? br_bit : '0;
        mult_valid   = s_valid[LAST] & ~|(s_bmask[LAST] & kill_mask);
        stall        = mult_valid & ~cdb_grant;
        mult_ready   = ~stall;
        mult_result  = (s_func[LAST] == UMULH) ? s_acc[LAST][127:64] : s_acc[LAST][63:0];
        mult_tagDest = s_tag[LAST];
        mult_bmask   = s_bmask[LAST] & ~clear_mask;
    end

`ifdef MULT_PERF_EN
    logic capture;

    assign capture = fus_en & mult_ready & ~|(fus_bmask & kill_mask);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mult_issue_cnt <= '0;
            mult_stall_cnt <= '0;
        end else begin
            if (capture) mult_issue_cnt <= mult_issue_cnt + 32'd1;
            if (stall)   mult_stall_cnt <= mult_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mult_fu.sv
// Scoreboard bench for mult_fu: stimulus pushes expected CDB results, a negedge monitor
// pops and compares them whenever a result is granted onto the CDB.
module tb_mult_fu;
    import mult_fu_pkg::*;

    typedef struct {
        logic [63:0] result;
        logic [5:0]  tag;
        logic [3:0]  bmask;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        fus_en;
    logic [63:0] fus_opA;
    logic [63:0] fus_opB;
    logic [5:0]  fus_tagDest;
    MULT_FUNC    fus_func;
    logic [3:0]  fus_bmask;
    logic        br_en;
    logic        br_mispredict;
    logic [1:0]  br_bs_ptr;
    logic        cdb_grant;
    logic        mult_ready;
    logic        mult_valid;
    logic [63:0] mult_result;
    logic [5:0]  mult_tagDest;
    logic [3:0]  mult_bmask;
`ifdef MULT_PERF_EN
    logic [31:0] mult_issue_cnt;
    logic [31:0] mult_stall_cnt;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mult_fu #(.STAGES(4), .BMASK_W(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .fus_en        (fus_en),
        .fus_opA       (fus_opA),
        .fus_opB       (fus_opB),
        .fus_tagDest   (fus_tagDest),
        .fus_func      (fus_func),
        .fus_bmask     (fus_bmask),
        .br_en         (br_en),
        .br_mispredict (br_mispredict),
        .br_bs_ptr     (br_bs_ptr),
        .cdb_grant     (cdb_grant),
        .mult_ready    (mult_ready),
        .mult_valid    (mult_valid),
        .mult_result   (mult_result),
        .mult_tagDest  (mult_tagDest),
        .mult_bmask    (mult_bmask)
`ifdef MULT_PERF_EN
        ,
        .mult_issue_cnt(mult_issue_cnt),
        .mult_stall_cnt(mult_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: every result accepted by the CDB must match the oldest expectation.
    always @(negedge clk) begin
        if (reset_n && mult_valid && cdb_grant) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_unexpected: got result %h tag %h, expected no result", mult_result, mult_tagDest);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (mult_result !== e.result || mult_tagDest !== e.tag || mult_bmask !== e.bmask) begin
                    errors++;
                    $display("[TB] FAIL sb_result: got %h/%h/%b, expected %h/%h/%b",
                             mult_result, mult_tagDest, mult_bmask, e.result, e.tag, e.bmask);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [63:0] a, input logic [63:0] b, input logic [5:0] tag,
                                 input MULT_FUNC func, input logic [3:0] bmask, input bit push,
                                 input logic [63:0] exp_result, input logic [3:0] exp_bmask);
        exp_t e;
        fus_en      = 1'b1;
        fus_opA     = a;
        fus_opB     = b;
        fus_tagDest = tag;
        fus_func    = func;
        fus_bmask   = bmask;
        if (push) begin
            e.result = exp_result;
            e.tag    = tag;
            e.bmask  = exp_bmask;
            sb.push_back(e);
        end
    endtask

    task automatic waitValid(input string name);
        int n = 0;
        while (!mult_valid && n < 12) begin
            tick();
            n++;
        end
        checks++;
        if (!mult_valid) begin
            errors++;
            $display("[TB] FAIL %s: mult_valid got 0 after %0d cycles, expected 1", name, n);
        end
    endtask

    initial begin
        reset_n = 1'b0; fus_en = 1'b0; fus_opA = '0; fus_opB = '0; fus_tagDest = '0;
        fus_func = MULQ; fus_bmask = '0; br_en = 1'b0; br_mispredict = 1'b0;
        br_bs_ptr = '0; cdb_grant = 1'b1;
        repeat (3) tick();
        checkOutput("rst_valid", 64'(mult_valid), 64'd0);
        checkOutput("rst_ready", 64'(mult_ready), 64'd1);
        checkOutput("rst_result", mult_result, 64'd0);
        checkOutput("rst_tag", 64'(mult_tagDest), 64'(`PHYS_ZERO_REG));
        checkOutput("rst_bmask", 64'(mult_bmask), 64'd0);
        reset_n = 1'b1;
        tick();

        // Latency: 3*5 visible exactly four cycles after fus_en
        applyStimulus(64'd3, 64'd5, 6'h10, MULQ, 4'b0000, 1'b1, 64'hF, 4'b0000);
        tick();
        fus_en = 1'b0;
        checkOutput("lat_c1", 64'(mult_valid), 64'd0);
        for (int i = 2; i <= 4; i++) begin
            tick();
            checkOutput($sformatf("lat_c%0d", i), 64'(mult_valid), (i == 4) ? 64'd1 : 64'd0);
        end
        tick();
        checkOutput("lat_after", 64'(mult_valid), 64'd0);

        // UMULH then back-to-back MULQ
        applyStimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'h11, UMULH, 4'b0000, 1'b1, 64'd1, 4'b0000);
        tick();
        applyStimulus(64'd7, 64'd9, 6'h12, MULQ, 4'b0000, 1'b1, 64'd63, 4'b0000);
        tick();
        applyStimulus(64'd2, 64'd2, 6'h13, MULQ, 4'b0000, 1'b1, 64'd4, 4'b0000);
        tick();
        fus_en = 1'b0;
        waitValid("b2b_first");
        checkOutput("b2b_umulh", mult_result, 64'd1);
        tick();
        checkOutput("b2b_v63", 64'(mult_valid), 64'd1);
        checkOutput("b2b_r63", mult_result, 64'd63);
        tick();
        checkOutput("b2b_v4", 64'(mult_valid), 64'd1);
        checkOutput("b2b_r4", mult_result, 64'd4);
        tick();
        checkOutput("b2b_idle", 64'(mult_valid), 64'd0);

        // Back-pressure: hold output, ignore new op, then retire and follow on
        cdb_grant = 1'b0;
        applyStimulus(64'd11, 64'd13, 6'h03, MULQ, 4'b0000, 1'b1, 64'd143, 4'b0000);
        tick();
        applyStimulus(64'd100, 64'd100, 6'h04, MULQ, 4'b0000, 1'b1, 64'd10000, 4'b0000);
        tick();
        fus_en = 1'b0;
        waitValid("stall_arrive");
        applyStimulus(64'd5, 64'd5, 6'h07, MULQ, 4'b0000, 1'b0, 64'd0, 4'b0000);
        checkOutput("stall_ready0", 64'(mult_ready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("stall_valid", 64'(mult_valid), 64'd1);
            checkOutput("stall_result", mult_result, 64'd143);
            checkOutput("stall_tag", 64'(mult_tagDest), 64'h03);
            checkOutput("stall_ready", 64'(mult_ready), 64'd0);
        end
        fus_en = 1'b0;
        cdb_grant = 1'b1;
        #1;
        checkOutput("stall_release", 64'(mult_ready), 64'd1);
        tick();
        checkOutput("stall_next_v", 64'(mult_valid), 64'd1);
        checkOutput("stall_next_r", mult_result, 64'd10000);
        tick();
        checkOutput("stall_drop", 64'(mult_valid), 64'd0);

        // Stalled output: combinational mask clear, then combinational squash
        cdb_grant = 1'b0;
        applyStimulus(64'd9, 64'd9, 6'h09, MULQ, 4'b1001, 1'b0, 64'd0, 4'b0000);
        tick();
        fus_en = 1'b0;
        waitValid("sq_arrive");
        checkOutput("sq_bmask0", 64'(mult_bmask), 64'b1001);
        br_en = 1'b1; br_mispredict = 1'b0; br_bs_ptr = 2'd0;
        #1;
        checkOutput("clr_comb", 64'(mult_bmask), 64'b1000);
        tick();
        br_en = 1'b0;
        #1;
        checkOutput("clr_reg", 64'(mult_bmask), 64'b1000);
        br_en = 1'b1; br_mispredict = 1'b1; br_bs_ptr = 2'd3;
        #1;
        checkOutput("sq_comb_valid", 64'(mult_valid), 64'd0);
        checkOutput("sq_comb_ready", 64'(mult_ready), 64'd1);
        tick();
        br_en = 1'b0;
        cdb_grant = 1'b1;
        checkOutput("sq_gone", 64'(mult_valid), 64'd0);

        // Mispredict mid-pipe: first op squashed, second on schedule, tagged incoming rejected
        applyStimulus(64'd6, 64'd7, 6'h01, MULQ, 4'b0010, 1'b0, 64'd0, 4'b0000);
        tick();
        applyStimulus(64'd8, 64'd8, 6'h02, MULQ, 4'b0000, 1'b1, 64'd64, 4'b0000);
        tick();
        applyStimulus(64'd3, 64'd3, 6'h0A, MULQ, 4'b0010, 1'b0, 64'd0, 4'b0000);
        br_en = 1'b1; br_mispredict = 1'b1; br_bs_ptr = 2'd1;
        tick();
        br_en = 1'b0;
        fus_en = 1'b0;
        tick();
        checkOutput("mp_squashed", 64'(mult_valid), 64'd0);
        tick();
        checkOutput("mp_second_v", 64'(mult_valid), 64'd1);
        checkOutput("mp_second_tag", 64'(mult_tagDest), 64'h02);
        tick();
        checkOutput("mp_incoming", 64'(mult_valid), 64'd0);

        // Correct resolve mid-pipe, then a mispredict on the same bit must not squash
        applyStimulus(64'h1_0000_0001, 64'h1_0000_0001, 6'h05, MULQ, 4'b0100, 1'b1,
                      64'h0000_0002_0000_0001, 4'b0000);
        tick();
        fus_en = 1'b0;
        tick();
        br_en = 1'b1; br_mispredict = 1'b0; br_bs_ptr = 2'd2;
        tick();
        br_mispredict = 1'b1;
        tick();
        checkOutput("cr_valid", 64'(mult_valid), 64'd1);
        checkOutput("cr_bmask", 64'(mult_bmask), 64'd0);
        checkOutput("cr_result", mult_result, 64'h0000_0002_0000_0001);
        tick();
        br_en = 1'b0;
        checkOutput("cr_idle", 64'(mult_valid), 64'd0);

        // Reset with three ops in flight
        applyStimulus(64'd1, 64'd1, 6'h21, MULQ, 4'b0000, 1'b0, 64'd0, 4'b0000);
        tick();
        applyStimulus(64'd2, 64'd3, 6'h22, MULQ, 4'b0000, 1'b0, 64'd0, 4'b0000);
        tick();
        applyStimulus(64'd4, 64'd5, 6'h23, MULQ, 4'b0000, 1'b0, 64'd0, 4'b0000);
        tick();
        fus_en = 1'b0;
        reset_n = 1'b0;
        #1;
        checkOutput("mr_valid", 64'(mult_valid), 64'd0);
        checkOutput("mr_tag", 64'(mult_tagDest), 64'(`PHYS_ZERO_REG));
        checkOutput("mr_ready", 64'(mult_ready), 64'd1);
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("mr_quiet", 64'(mult_valid), 64'd0);
        end

        checkOutput("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_fu.md
Name: mult_fu

Overview:
- Pipelined 64x64 integer multiply functional unit, directly downstream of the FUS selector.
- Consumes the single selected op (enable, operands, dest tag, branch mask, func) and produces a tagged result for CDB broadcast.
- Fully pipelined: accepts one op per cycle unless stalled by CDB back-pressure.
- Tracks branch speculation: squashes ops on mispredict and clears mask bits on correct resolve.

Parameters:
- STAGES, 4, pipeline depth; legal values 1, 2, 4, 8 (must divide 64); each stage adds a 64/STAGES-bit slice of opB.
- BMASK_W, 4, branch mask width (number of in-flight branches); BS_PTR width is $clog2(BMASK_W).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- fus_en  in  1  valid op presented by FUS
- fus_opA  in  64  DATA operand A
- fus_opB  in  64  DATA operand B
- fus_tagDest  in  6  PHYS_REG destination tag
- fus_func  in  1  MULT_FUNC: 0 = MULQ (low 64 bits), 1 = UMULH (high 64 bits, unsigned)
- fus_bmask  in  BMASK_W  branch mask of the op
- br_en  in  1  branch resolution this cycle
- br_mispredict  in  1  qualifies br_en; 1 = mispredict
- br_bs_ptr  in  $clog2(BMASK_W)  index of the resolving branch bit
- cdb_grant  in  1  CDB accepts mult output this cycle
- mult_ready  out  1  stage 0 can accept (= ~stall)
- mult_valid  out  1  result valid for CDB
- mult_result  out  64  DATA result
- mult_tagDest  out  6  PHYS_REG result tag
- mult_bmask  out  BMASK_W  current mask of the output op

Behaviour:
- Reset (async, reset_n low): all stage valids 0; mult_valid 0, mult_result 0, mult_tagDest = `PHYS_ZERO_REG, mult_bmask 0, mult_ready 1. Operand/accumulator registers are cleared to 0.
- Stage register Si holds: valid, opA, opB, tag, func, bmask, and a 128-bit accumulator containing the sum of the partial products for slices 0..i.
- Capture: on a clock edge with fus_en & mult_ready, S0 takes the inputs, with acc = opA * opB[W-1:0], where W = 64/STAGES.
- Advance: on each non-stalled edge, S(i+1) <= Si, adding opA * opB[W(i+1)+W-1 : W(i+1)] << W(i+1).
- Latency: an op captured at edge k is presented on mult_valid after edge k+STAGES-1; i.e. STAGES cycles from fus_en to a visible result. Throughput is 1 op per cycle.
- Output: mult_result = acc[63:0] for MULQ, acc[127:64] for UMULH; tag and bmask come from S(STAGES-1).
- Stall: stall = S(STAGES-1).valid & ~cdb_grant.
  - While stalled, all stages hold (global freeze, no bubble collapse) and mult_ready = 0.
  - An fus_en presented while mult_ready = 0 is not captured; the RS/FUS must hold or reissue the op.
- Mispredict (br_en & br_mispredict): every stage whose bmask[br_bs_ptr] = 1 has its valid cleared at the edge, regardless of stall.
  - An incoming op with that bit set is not captured.
  - mult_valid is combinationally masked: mult_valid = S(last).valid & ~(br_en & br_mispredict & S(last).bmask[br_bs_ptr]). A squashed output therefore also deasserts stall in the same cycle.
- Correct resolve (br_en & ~br_mispredict): bit br_bs_ptr is cleared in every stage's bmask and in the incoming fus_bmask at capture.
  - mult_bmask shows the cleared value combinationally in the same cycle.
- Simultaneous grant and advance: a granted output leaves at the same edge the pipeline advances, with no bubble inserted.
- Reset asserted mid-operation: all in-flight ops are discarded immediately (async); no result is emitted.

Optional Feature:
- MULT_PERF_EN: when defined, adds outputs mult_issue_cnt [31:0] (count of captured ops) and mult_stall_cnt [31:0] (count of cycles with stall = 1).
  - Both counters are reset to 0 by reset_n and wrap at 2^32.
- Without the macro, these ports and counters do not exist.

Decomposition:
- Shared sys_defs package: DATA, PHYS_REG, B_MASK, BS_PTR, `PHYS_ZERO_REG, and a MULT_FUNC enum {MULQ, UMULH}.
- One sub-module, mult_stage: a single pipeline register plus its partial-product add, including the bmask clear/squash logic. mult_fu instantiates STAGES copies of it in a generate loop.

Test Plan:
- Reset then MULQ 3*5, tag 6'h10, cdb_grant=1: mult_valid=1 exactly 4 cycles later, with result 64'hF and tag 6'h10; mult_valid=0 otherwise.
- UMULH 64'hFFFF_FFFF_FFFF_FFFF * 2: result 64'h1. Then back-to-back MULQ 7*9 and 2*2 on consecutive cycles: results 63 and 4 on consecutive cycles.
- Op at output with cdb_grant=0 for 3 cycles: mult_valid, result and tag held stable, mult_ready=0, new fus_en ignored. Then grant=1: result retires and the next op follows on the next cycle.
- Two in flight with bmask 4'b0010 and 4'b0000; br_en=1, mispredict=1, ptr=1: the first op never appears, the second op's result appears on schedule.
- Op with bmask 4'b0100; br_en=1, mispredict=0, ptr=2 mid-pipe: output has mult_bmask 4'b0000 and a correct result. A later mispredict on ptr 2 does not squash it.
- reset_n pulsed low with 3 ops in flight: mult_valid=0 immediately, tag = `PHYS_ZERO_REG, and no results emitted after reset release.
